instr_fetch_buf: RTL

Byte-serial instruction fetch unit with a small prefetch FIFO, upstream of the single-cycle processor core. It reads the byte-wide instruction memory four bytes per instruction and assembles each big-endian 32-bit word, byte at address A into bits [31:24]. Completed words are buffered with their PC and handed to the core over a valid/ready handshake. A redirect input (taken branch, jump, jalfor loop-back) flushes the FIFO and restarts fetch at a new PC.

---
 rtl/instr_fetch_buf_if.sv | 29 ++
 rtl/instr_fetch_buf.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buf_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_buf_if : memory, redirect and core handshake bundle for instr_fetch_buf
// Rev 1.0
// ----------------------------------------------------------------------------
interface instr_fetch_buf_if #(
  parameter int ADDR_W = 5
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_ready;

  modport master (
    output mem_rd, mem_addr, instr_valid, instr, instr_pc,
    input  mem_data, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_rd, mem_addr, instr_valid, instr, instr_pc,
    output mem_data, redirect, redirect_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_buf : byte-serial big-endian fetch into FWFT prefetch FIFO; macro IFETCH_PERF_EN adds starve_cnt
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_fetch_buf #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input wire clk,
  input wire reset,
  instr_fetch_buf_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] starve_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [1:0]       r_b;
  logic [1:0]       w_b_nxt;
  logic [31:0]      r_fetch_pc;

  logic             r_cap_vld;
  logic [1:0]       r_cap_idx;
  logic [31:0]      r_cap_pc;
  logic [23:0]      r_asm;

  logic [31:0]      r_fifo_instr [DEPTH];
  logic [31:0]      r_fifo_pc    [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic [31:0]      w_word;
  logic [1:0]       w_inflight;
  logic [31:0]      w_occ;
  logic             w_room;
  logic             w_unused;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & bus.instr_ready & ~bus.redirect;
  assign w_push   = r_cap_vld & (r_cap_idx == 2'd3) & ~bus.redirect;
  assign w_word   = {r_asm, bus.mem_data};
  assign w_unused = ^bus.redirect_pc[1:0];

  // A word is in flight from its first issue until its last byte is captured.
  assign w_inflight = {1'b0, (r_state == S_ISSUE)} +
                      {1'b0, (r_cap_vld && (r_cap_idx == 2'd3))};
  assign w_occ      = 32'(r_count) + 32'(w_inflight) - 32'(w_pop);
  assign w_room     = (w_occ < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_b     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_b     <= w_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    if (bus.redirect) begin
      w_state_nxt = S_IDLE;
      w_b_nxt     = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_b_nxt = 2'd0;
          if (w_room) w_state_nxt = S_ISSUE;
        end
        S_ISSUE: begin
          if (r_b == 2'd3) begin
            w_b_nxt     = 2'd0;
            w_state_nxt = w_room ? S_ISSUE : S_IDLE;
          end else begin
            w_b_nxt = r_b + 2'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_b_nxt     = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_addr = '0;
    if (r_state == S_ISSUE) begin
      bus.mem_rd   = 1'b1;
      bus.mem_addr = r_fetch_pc[ADDR_W-1:0] + ADDR_W'(r_b);
    end
  end

  // Capture stage trails issue by one cycle; redirect kills the returning byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= 32'd0;
      r_cap_vld  <= 1'b0;
      r_cap_idx  <= 2'd0;
      r_cap_pc   <= 32'd0;
      r_asm      <= 24'd0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_cap_vld <= bus.mem_rd & ~bus.redirect;
      r_cap_idx <= r_b;
      r_cap_pc  <= r_fetch_pc;
      if (r_cap_vld) r_asm <= w_word[23:0];
      if (bus.redirect) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if ((r_state == S_ISSUE) && (r_b == 2'd3)) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= w_word;
      r_fifo_pc[r_wr_ptr]    <= r_cap_pc;
    end
  end

  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
  assign bus.instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr]    : 32'd0;

`ifdef IFETCH_PERF_EN
  logic [15:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 16'd0;
    end else if (bus.instr_ready && !w_valid && (r_starve_cnt != 16'hFFFF)) begin
      r_starve_cnt <= r_starve_cnt + 16'd1;
    end
  end

  assign starve_cnt = r_starve_cnt;
`endif

endmodule
`default_nettype wire
